// File: rtl/rename_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_pkg : shared types and constants for the register-rename stage
// rev 1.0
// ---------------------------------------------------------------------------
package rename_pkg;

  localparam int DEF_PHY_REG_NUM  = 64;
  localparam int DEF_ARCH_REG_NUM = 32;
  localparam int PREG_W           = $clog2(DEF_PHY_REG_NUM);
  localparam int AREG_W           = $clog2(DEF_ARCH_REG_NUM);

  typedef logic [AREG_W-1:0] arch_reg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } rename_lane_t;

  localparam arch_reg_t ARCH_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/rename_compact.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_compact : prefix-count compactor, sparse lane mask -> dense index
// rev 1.0
// ---------------------------------------------------------------------------
module rename_compact
  import rename_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1,
  parameter int TW = $clog2(N + 1)
) (
  input  logic [N-1:0]    mask_i,
  output logic [N*IW-1:0] idx_o,
  output logic [TW-1:0]   total_o
);

  logic [TW-1:0] cnt;

  // idx_o[i] counts the set mask bits strictly below lane i
  always_comb begin
    cnt   = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      idx_o[i*IW +: IW] = IW'(cnt);
      cnt = cnt + TW'(mask_i[i]);
    end
    total_o = cnt;
  end

endmodule
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_table : speculative/architectural alias tables, group rename, commit free
// rev 1.0
// ---------------------------------------------------------------------------
module rename_table
  import rename_pkg::*;
#(
  parameter int PHY_REG_NUM  = DEF_PHY_REG_NUM,
  parameter int ARCH_REG_NUM = DEF_ARCH_REG_NUM,
  parameter int DECODE_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int PW = $clog2(PHY_REG_NUM),
  localparam int AW = $clog2(ARCH_REG_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [DECODE_WIDTH-1:0]    rn_valid_i,
  output logic                       rn_ready_o,
  input  logic [DECODE_WIDTH*AW-1:0] rn_rs1_i,
  input  logic [DECODE_WIDTH*AW-1:0] rn_rs2_i,
  input  logic [DECODE_WIDTH*AW-1:0] rn_rd_i,
  input  logic [DECODE_WIDTH-1:0]    rn_rd_we_i,
  output logic [DECODE_WIDTH-1:0]    alloc_valid_o,
  input  logic                       alloc_ready_i,
  input  logic [DECODE_WIDTH*PW-1:0] alloc_preg_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DECODE_WIDTH-1:0]    out_lane_valid_o,
  output logic [DECODE_WIDTH*PW-1:0] out_prs1_o,
  output logic [DECODE_WIDTH*PW-1:0] out_prs2_o,
  output logic [DECODE_WIDTH*PW-1:0] out_prd_o,
  output logic [DECODE_WIDTH*PW-1:0] out_old_prd_o,
  input  logic [COMMIT_WIDTH-1:0]    cm_valid_i,
  input  logic [COMMIT_WIDTH*AW-1:0] cm_rd_i,
  input  logic [COMMIT_WIDTH*PW-1:0] cm_prd_i,
  input  logic [COMMIT_WIDTH-1:0]    cm_rd_we_i,
  output logic [COMMIT_WIDTH-1:0]    free_valid_o,
  output logic [COMMIT_WIDTH*PW-1:0] free_preg_o
);

  localparam int DIW = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;
  localparam int DTW = $clog2(DECODE_WIDTH + 1);
  localparam int CIW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
  localparam int CTW = $clog2(COMMIT_WIDTH + 1);

  preg_t        spec_q [ARCH_REG_NUM];
  preg_t        spec_d [ARCH_REG_NUM];
  preg_t        arch_q [ARCH_REG_NUM];
  preg_t        arch_d [ARCH_REG_NUM];
  logic         out_valid_q, out_valid_d;
  rename_lane_t out_q [DECODE_WIDTH];
  rename_lane_t out_d [DECODE_WIDTH];
  logic [COMMIT_WIDTH-1:0] free_valid_q, free_valid_d;
  preg_t        free_preg_q [COMMIT_WIDTH];
  preg_t        free_preg_d [COMMIT_WIDTH];

  arch_reg_t    rs1 [DECODE_WIDTH];
  arch_reg_t    rs2 [DECODE_WIDTH];
  arch_reg_t    rd  [DECODE_WIDTH];
  preg_t        alloc_preg [DECODE_WIDTH];
  preg_t        new_preg   [DECODE_WIDTH];
  rename_lane_t ren [DECODE_WIDTH];
  logic [DECODE_WIDTH-1:0]     alloc_lane;
  logic [DECODE_WIDTH*DIW-1:0] alloc_idx;
  logic [DTW-1:0]              alloc_total;
  logic                        fire;

  arch_reg_t    cm_rd  [COMMIT_WIDTH];
  preg_t        cm_prd [COMMIT_WIDTH];
  preg_t        cm_old [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0]     free_mask;
  logic [COMMIT_WIDTH*CIW-1:0] free_idx;
  logic [CTW-1:0]              free_total;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_rn_lane
    assign rs1[g]        = rn_rs1_i[g*AW +: AW];
    assign rs2[g]        = rn_rs2_i[g*AW +: AW];
    assign rd[g]         = rn_rd_i[g*AW +: AW];
    assign alloc_preg[g] = alloc_preg_i[g*PW +: PW];
    assign alloc_lane[g] = rn_valid_i[g] && rn_rd_we_i[g] && (rd[g] != ARCH_ZERO);

    assign out_lane_valid_o[g]        = out_q[g].valid;
    assign out_prs1_o[g*PW +: PW]     = out_q[g].prs1;
    assign out_prs2_o[g*PW +: PW]     = out_q[g].prs2;
    assign out_prd_o[g*PW +: PW]      = out_q[g].prd;
    assign out_old_prd_o[g*PW +: PW]  = out_q[g].old_prd;
  end

  for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_cm_lane
    assign cm_rd[g]                 = cm_rd_i[g*AW +: AW];
    assign cm_prd[g]                = cm_prd_i[g*PW +: PW];
    assign free_preg_o[g*PW +: PW]  = free_preg_q[g];
  end

  assign free_valid_o = free_valid_q;
  assign out_valid_o  = out_valid_q;

  rename_compact #(.N(DECODE_WIDTH)) u_alloc_compact (
    .mask_i  (alloc_lane),
    .idx_o   (alloc_idx),
    .total_o (alloc_total)
  );

  rename_compact #(.N(COMMIT_WIDTH)) u_free_compact (
    .mask_i  (free_mask),
    .idx_o   (free_idx),
    .total_o (free_total)
  );

  assign rn_ready_o = alloc_ready_i && (!out_valid_q || out_ready_i) && !flush_i;
  assign fire       = (|rn_valid_i) && rn_ready_o;

  // The free list pops its head unconditionally, so requests only go out on fire
  always_comb begin
    alloc_valid_o = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      alloc_valid_o[j] = fire && (DTW'(j) < alloc_total);
      new_preg[j]      = alloc_preg[alloc_idx[j*DIW +: DIW]];
    end
  end

  // Lookup through spec_rat, overridden by the youngest older lane writing the same reg
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      ren[i] = '0;
      if (rn_valid_i[i]) begin
        ren[i].valid   = 1'b1;
        ren[i].prs1    = spec_q[rs1[i]];
        ren[i].prs2    = spec_q[rs2[i]];
        ren[i].old_prd = spec_q[rd[i]];
        for (int j = 0; j < i; j++) begin
          if (alloc_lane[j]) begin
            if (rd[j] == rs1[i]) ren[i].prs1    = new_preg[j];
            if (rd[j] == rs2[i]) ren[i].prs2    = new_preg[j];
            if (rd[j] == rd[i])  ren[i].old_prd = new_preg[j];
          end
        end
        if (rs1[i] == ARCH_ZERO) ren[i].prs1 = '0;
        if (rs2[i] == ARCH_ZERO) ren[i].prs2 = '0;
        if (alloc_lane[i]) ren[i].prd     = new_preg[i];
        else               ren[i].old_prd = '0;
      end
    end
  end

  // Commit walk: each lane sees the arch table as updated by older lanes
  always_comb begin
    arch_d    = arch_q;
    free_mask = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cm_old[i] = '0;
      if (cm_valid_i[i] && cm_rd_we_i[i] && (cm_rd[i] != ARCH_ZERO)) begin
        cm_old[i]        = arch_d[cm_rd[i]];
        free_mask[i]     = 1'b1;
        arch_d[cm_rd[i]] = cm_prd[i];
      end
    end
  end

  always_comb begin
    free_valid_d = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      free_valid_d[j] = (CTW'(j) < free_total);
      free_preg_d[j]  = '0;
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (free_mask[i]) free_preg_d[free_idx[i*CIW +: CIW]] = cm_old[i];
    end
  end

  always_comb begin
    spec_d = spec_q;
    if (flush_i) begin
      spec_d = arch_d;
    end else if (fire) begin
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (alloc_lane[i]) spec_d[rd[i]] = new_preg[i];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      out_d       = ren;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) begin
        spec_q[i] <= preg_t'(i);
        arch_q[i] <= preg_t'(i);
      end
      out_valid_q <= 1'b0;
      for (int i = 0; i < DECODE_WIDTH; i++) out_q[i] <= '0;
      free_valid_q <= '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) free_preg_q[i] <= '0;
    end else begin
      spec_q       <= spec_d;
      arch_q       <= arch_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      free_valid_q <= free_valid_d;
      free_preg_q  <= free_preg_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rename_table : directed pins plus random traffic against a sequential model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_rename_table;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int DW = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;
  logic [DW-1:0]    rn_valid_i;
  logic             rn_ready_o;
  logic [DW*AW-1:0] rn_rs1_i, rn_rs2_i, rn_rd_i;
  logic [DW-1:0]    rn_rd_we_i;
  logic [DW-1:0]    alloc_valid_o;
  logic             alloc_ready_i;
  logic [DW*PW-1:0] alloc_preg_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DW-1:0]    out_lane_valid_o;
  logic [DW*PW-1:0] out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o;
  logic [CW-1:0]    cm_valid_i;
  logic [CW*AW-1:0] cm_rd_i;
  logic [CW*PW-1:0] cm_prd_i;
  logic [CW-1:0]    cm_rd_we_i;
  logic [CW-1:0]    free_valid_o;
  logic [CW*PW-1:0] free_preg_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rename_table dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .rn_valid_i(rn_valid_i), .rn_ready_o(rn_ready_o),
    .rn_rs1_i(rn_rs1_i), .rn_rs2_i(rn_rs2_i), .rn_rd_i(rn_rd_i), .rn_rd_we_i(rn_rd_we_i),
    .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i), .alloc_preg_i(alloc_preg_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_lane_valid_o(out_lane_valid_o),
    .out_prs1_o(out_prs1_o), .out_prs2_o(out_prs2_o), .out_prd_o(out_prd_o),
    .out_old_prd_o(out_old_prd_o),
    .cm_valid_i(cm_valid_i), .cm_rd_i(cm_rd_i), .cm_prd_i(cm_prd_i), .cm_rd_we_i(cm_rd_we_i),
    .free_valid_o(free_valid_o), .free_preg_o(free_preg_o)
  );

  task automatic chk(input string nm, input int lane, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, lane, $time, act, exp);
    end
  endtask

  function automatic int o_prs1(int i); return int'(out_prs1_o[i*PW +: PW]); endfunction
  function automatic int o_prs2(int i); return int'(out_prs2_o[i*PW +: PW]); endfunction
  function automatic int o_prd(int i);  return int'(out_prd_o[i*PW +: PW]); endfunction
  function automatic int o_old(int i);  return int'(out_old_prd_o[i*PW +: PW]); endfunction
  function automatic int o_free(int i); return int'(free_preg_o[i*PW +: PW]); endfunction

  // Reference model: rename is the sequential in-order effect of each lane on a table copy
  int spec_m [32];
  int arch_m [32];
  int tmp_m  [32];
  bit m_out_valid;
  bit m_lane_valid [DW];
  bit m_alloc [DW];
  int m_prs1 [DW];
  int m_prs2 [DW];
  int m_prd  [DW];
  int m_old  [DW];
  int m_free [CW];
  int m_free_n;
  int mk, mn, mrd;
  bit mfire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        spec_m[r] = r;
        arch_m[r] = r;
      end
      m_out_valid = 1'b0;
      m_free_n    = 0;
    end else begin
      mfire = (rn_valid_i != '0) && alloc_ready_i && (!m_out_valid || out_ready_i) && !flush_i;
      mn = 0;
      for (int i = 0; i < CW; i++) begin
        mrd = int'(cm_rd_i[i*AW +: AW]);
        if (cm_valid_i[i] && cm_rd_we_i[i] && mrd != 0) begin
          m_free[mn] = arch_m[mrd];
          mn++;
          arch_m[mrd] = int'(cm_prd_i[i*PW +: PW]);
        end
      end
      m_free_n = mn;
      if (flush_i) begin
        spec_m      = arch_m;
        m_out_valid = 1'b0;
      end else if (mfire) begin
        tmp_m = spec_m;
        mk = 0;
        for (int i = 0; i < DW; i++) begin
          m_lane_valid[i] = rn_valid_i[i];
          m_alloc[i] = 1'b0;
          if (rn_valid_i[i]) begin
            mrd       = int'(rn_rd_i[i*AW +: AW]);
            m_prs1[i] = tmp_m[int'(rn_rs1_i[i*AW +: AW])];
            m_prs2[i] = tmp_m[int'(rn_rs2_i[i*AW +: AW])];
            m_old[i]  = tmp_m[mrd];
            m_prd[i]  = 0;
            if (rn_rd_we_i[i] && mrd != 0) begin
              m_prd[i]   = int'(alloc_preg_i[mk*PW +: PW]);
              mk++;
              tmp_m[mrd] = m_prd[i];
              m_alloc[i] = 1'b1;
            end
          end
        end
        spec_m      = tmp_m;
        m_out_valid = 1'b1;
      end else if (out_ready_i) begin
        m_out_valid = 1'b0;
      end
    end
  end

  // Compare process: inputs settle two units after posedge, outputs sampled on negedge
  int  c_nalloc;
  bit  c_ready, c_fire;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 0, int'(out_valid_o), 0);
      chk("rst_free_valid", 0, int'(free_valid_o), 0);
      chk("rst_out_data", 0,
          int'(|{out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o, out_lane_valid_o}), 0);
      chk("rst_free_preg", 0, int'(|free_preg_o), 0);
    end else begin
      c_ready  = alloc_ready_i && (!m_out_valid || out_ready_i) && !flush_i;
      c_fire   = (rn_valid_i != '0) && c_ready;
      c_nalloc = 0;
      for (int i = 0; i < DW; i++)
        if (rn_valid_i[i] && rn_rd_we_i[i] && rn_rd_i[i*AW +: AW] != '0) c_nalloc++;
      chk("rn_ready", 0, int'(rn_ready_o), int'(c_ready));
      chk("alloc_valid", 0, int'(alloc_valid_o), c_fire ? ((1 << c_nalloc) - 1) : 0);
      chk("out_valid", 0, int'(out_valid_o), int'(m_out_valid));
      if (m_out_valid) begin
        for (int i = 0; i < DW; i++) begin
          chk("lane_valid", i, int'(out_lane_valid_o[i]), int'(m_lane_valid[i]));
          if (m_lane_valid[i]) begin
            chk("prs1", i, o_prs1(i), m_prs1[i]);
            chk("prs2", i, o_prs2(i), m_prs2[i]);
            chk("prd", i, o_prd(i), m_prd[i]);
            if (m_alloc[i]) chk("old_prd", i, o_old(i), m_old[i]);
          end
        end
      end
      chk("free_valid", 0, int'(free_valid_o), (1 << m_free_n) - 1);
      for (int i = 0; i < m_free_n; i++) chk("free_preg", i, o_free(i), m_free[i]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    rn_valid_i    = '0;
    rn_rs1_i      = '0;
    rn_rs2_i      = '0;
    rn_rd_i       = '0;
    rn_rd_we_i    = '0;
    alloc_preg_i  = '0;
    alloc_ready_i = 1'b1;
    out_ready_i   = 1'b1;
    cm_valid_i    = '0;
    cm_rd_i       = '0;
    cm_prd_i      = '0;
    cm_rd_we_i    = '0;
  endtask

  task automatic set_lane(input int i, input int s1, input int s2, input int d,
                          input bit we, input int preg);
    rn_rs1_i[i*AW +: AW]     = AW'(s1);
    rn_rs2_i[i*AW +: AW]     = AW'(s2);
    rn_rd_i[i*AW +: AW]      = AW'(d);
    rn_rd_we_i[i]            = we;
    alloc_preg_i[i*PW +: PW] = PW'(preg);
  endtask

  task automatic set_cm(input int i, input int d, input bit we, input int preg);
    cm_valid_i[i]        = 1'b1;
    cm_rd_i[i*AW +: AW]  = AW'(d);
    cm_rd_we_i[i]        = we;
    cm_prd_i[i*PW +: PW] = PW'(preg);
  endtask

  int nv;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Group with intra-group dependency
    set_lane(0, 5, 0, 5, 1'b1, 40);
    set_lane(1, 5, 0, 7, 1'b1, 41);
    rn_valid_i = 4'b0011;
    #1;
    chk("t1_alloc_valid", 0, int'(alloc_valid_o), 3);
    chk("t1_rn_ready", 0, int'(rn_ready_o), 1);
    cyc(); idle();
    chk("t1_prs1", 0, o_prs1(0), 5);
    chk("t1_prd", 0, o_prd(0), 40);
    chk("t1_old", 0, o_old(0), 5);
    chk("t1_prs1", 1, o_prs1(1), 40);
    chk("t1_prd", 1, o_prd(1), 41);

    // All four lanes write rd=3, then a dependent group with no bubble
    for (int i = 0; i < DW; i++) set_lane(i, 0, 0, 3, 1'b1, 50 + i);
    rn_valid_i = 4'b1111;
    cyc(); idle();
    chk("t2_old", 0, o_old(0), 3);
    chk("t2_old", 1, o_old(1), 50);
    chk("t2_old", 2, o_old(2), 51);
    chk("t2_old", 3, o_old(3), 52);
    set_lane(0, 3, 0, 0, 1'b0, 0);
    rn_valid_i = 4'b0001;
    cyc(); idle();
    chk("t2_prs1", 0, o_prs1(0), 53);
    chk("t2_prd_noalloc", 0, o_prd(0), 0);

    // Free list not ready
    alloc_ready_i = 1'b0;
    set_lane(0, 0, 0, 6, 1'b1, 30);
    rn_valid_i = 4'b0001;
    #1;
    chk("t3_rn_ready", 0, int'(rn_ready_o), 0);
    chk("t3_alloc_valid", 0, int'(alloc_valid_o), 0);
    cyc(); idle();
    chk("t3_out_valid", 0, int'(out_valid_o), 0);

    // Output stall for three cycles
    set_lane(0, 0, 0, 10, 1'b1, 20);
    rn_valid_i = 4'b0001;
    cyc();
    out_ready_i = 1'b0;
    set_lane(0, 0, 0, 11, 1'b1, 21);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t4_rn_ready_stall", s, int'(rn_ready_o), 0);
      cyc();
      chk("t4_out_valid_stall", s, int'(out_valid_o), 1);
      chk("t4_prd_stall", s, o_prd(0), 20);
    end
    out_ready_i = 1'b1;
    #1;
    chk("t4_rn_ready_release", 0, int'(rn_ready_o), 1);
    cyc(); idle();
    chk("t4_prd_next", 0, o_prd(0), 21);
    chk("t4_old_next", 0, o_old(0), 11);

    // Two commits to the same rd: second sees the first through the bypass
    set_cm(0, 4, 1'b1, 60);
    set_cm(1, 4, 1'b1, 61);
    cyc(); idle();
    chk("t5_free_valid", 0, int'(free_valid_o), 3);
    chk("t5_free_preg", 0, o_free(0), 4);
    chk("t5_free_preg", 1, o_free(1), 60);
    cyc();
    chk("t5_free_once", 0, int'(free_valid_o), 0);

    // Flush drops speculative rd=9 and any group in the flush cycle
    set_lane(0, 0, 0, 9, 1'b1, 45);
    rn_valid_i = 4'b0001;
    cyc(); idle();
    cyc();
    flush_i = 1'b1;
    set_lane(0, 9, 0, 12, 1'b1, 33);
    rn_valid_i = 4'b0001;
    #1;
    chk("t6_rn_ready_flush", 0, int'(rn_ready_o), 0);
    chk("t6_alloc_flush", 0, int'(alloc_valid_o), 0);
    cyc(); idle();
    chk("t6_out_valid_flush", 0, int'(out_valid_o), 0);
    set_lane(0, 9, 4, 0, 1'b0, 0);
    rn_valid_i = 4'b0001;
    cyc(); idle();
    chk("t6_prs1_restored", 0, o_prs1(0), 9);
    chk("t6_prs2_arch4", 0, o_prs2(0), 61);

    // Commit in the flush cycle is included in the restore
    set_lane(0, 0, 0, 9, 1'b1, 45);
    rn_valid_i = 4'b0001;
    cyc(); idle();
    flush_i = 1'b1;
    set_cm(0, 9, 1'b1, 45);
    cyc(); idle();
    chk("t6_free_flush", 0, o_free(0), 9);
    set_lane(0, 9, 0, 0, 1'b0, 0);
    rn_valid_i = 4'b0001;
    cyc(); idle();
    chk("t6_prs1_committed", 0, o_prs1(0), 45);

    // Random traffic, with one asynchronous reset pulse mid-run
    for (int c = 0; c < 3000; c++) begin
      if (c == 1501) rst_n = 1'b1;
      idle();
      nv = $urandom_range(0, DW);
      rn_valid_i = DW'((1 << nv) - 1);
      for (int i = 0; i < DW; i++)
        set_lane(i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63));
      alloc_ready_i = ($urandom_range(0, 7) != 0);
      out_ready_i   = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 19) == 0);
      nv = $urandom_range(0, CW);
      for (int i = 0; i < nv; i++)
        set_cm(i, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 63));
      if (c == 1500) #1 rst_n = 1'b0;
      cyc();
    end

    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rename_table.md
# rename_table

Register-rename stage between decode and dispatch. It consumes the physical registers handed out by the free-list allocator and maps each group's architectural sources and destinations onto physical registers. It keeps a speculative alias table and an architectural alias table, and on commit returns superseded physical registers to the free list. The architectural table is also used to restore state on a pipeline flush.

## Interface
- PHY_REG_NUM, 64, physical register count; must be a power of 2; PW = $clog2(PHY_REG_NUM)
- ARCH_REG_NUM, 32, architectural register count; AW = $clog2(ARCH_REG_NUM); arch reg 0 is hardwired zero
- DECODE_WIDTH, 4, rename lanes per cycle
- COMMIT_WIDTH, 4, commit lanes per cycle
- Clocking and reset (already decided): reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all speculative state
- rn_valid_i  in  DECODE_WIDTH  lane valid; contiguous from [0]
- rn_ready_o  out  1  group accepted when any rn_valid_i && rn_ready_o
- rn_rs1_i, rn_rs2_i, rn_rd_i  in  DECODE_WIDTH×AW  arch sources and destination
- rn_rd_we_i  in  DECODE_WIDTH  lane writes rd
- alloc_valid_o  out  DECODE_WIDTH  request to free list; contiguous from [0]
- alloc_ready_i  in  1  free list holds ≥ DECODE_WIDTH entries
- alloc_preg_i  in  DECODE_WIDTH×PW  allocated pregs, compacted by request index
- out_valid_o  out  1  renamed group valid
- out_ready_i  in  1  dispatch accepts the group
- out_lane_valid_o  out  DECODE_WIDTH  lane mask of the renamed group
- out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o  out  DECODE_WIDTH×PW  renamed operands; out_old_prd_o is the prior mapping of rd
- cm_valid_i  in  COMMIT_WIDTH  committing lanes; contiguous from [0]
- cm_rd_i  in  COMMIT_WIDTH×AW / cm_prd_i  in  COMMIT_WIDTH×PW / cm_rd_we_i  in  COMMIT_WIDTH  committed destination
- free_valid_o  out  COMMIT_WIDTH  pregs returned to free list; contiguous from [0]
- free_preg_o  out  COMMIT_WIDTH×PW  returned pregs

## Operation
- A lane allocates if rn_valid_i[i] && rn_rd_we_i[i] && rn_rd_i[i]≠0. k(i) is the number of allocating lanes below i; lane i takes alloc_preg_i[k(i)].
- fire = |rn_valid_i && rn_ready_o.
- rn_ready_o = alloc_ready_i && (!out_valid_o || out_ready_i) && !flush_i.
- alloc_valid_o[j] = fire && (j < total allocating lanes). It is asserted only on fire, because the free list advances its head unconditionally.
- Source lookup: the speculative table (spec_rat) supplies the mapping. If an older lane in the group (j<i) allocates the same arch reg, that lane's new preg is used instead; the youngest such j wins. out_old_prd_o uses the same bypass. Arch reg 0 always maps to preg 0, and a lane that does not allocate has out_prd_o = 0.
- On fire, spec_rat is updated with each allocating lane's rd → new preg. If several lanes write the same rd, the highest lane wins.
- Commit: lanes are walked in order with the architectural table (arch_rat) bypassed by older commit lanes. Each lane with cm_rd_we_i && rd≠0 frees its old mapping and writes cm_prd_i. Freed pregs are compacted into free_valid_o / free_preg_o.
- Flush: spec_rat ← arch_rat, including this cycle's commits. out_valid_o is cleared, there is no fire, and commit frees still issue.
- Reset: spec_rat[i] = arch_rat[i] = i. out_valid_o = 0, free_valid_o = 0, all data outputs = 0.

## Timing
- Rename latency is 1 cycle: a group that fires at edge N appears on the out_* registers after edge N and holds until out_valid_o && out_ready_i.
- spec_rat writes are visible to the next group with no bubble. Back-to-back dependent groups must rename correctly.
- Free latency is 1 cycle: commits sampled at edge N appear on free_valid_o for exactly one cycle after N. There is no backpressure.
- Commit and rename in the same cycle use independent tables and do not interact, except on flush.
- Flush asserted in the same cycle as rn_valid_i: the group is dropped, no allocation occurs, and the spec_rat restore wins.
- Reset mid-operation clears all state immediately, asynchronously.

## Structure
- Package rename_pkg holds the arch_reg_t and preg_t typedefs, the rename lane struct {valid, prs1, prs2, prd, old_prd}, and the ARCH_ZERO constant.
- Sub-module rename_compact: a parameterised prefix-count compactor that maps a sparse lane mask to a contiguous index. It is used for both the alloc and free paths.

## Test plan
- Reset, then one group of lanes 0-1: lane0 rd=5, rs1=5; lane1 rs1=5, rd=7 with alloc_preg_i={40,41}. Expected: lane0 prs1=5, prd=40, old_prd=5; lane1 prs1=40, prd=41; alloc_valid_o=0b0011.
- Four lanes all writing rd=3 with pregs 50..53. Expected: a following group reads rs1=3 → 53, and old_prd follows the chain 3,50,51,52.
- alloc_ready_i=0 with a valid group. Expected: rn_ready_o=0, alloc_valid_o=0, and out_valid_o is not asserted.
- Output stall: out_ready_i=0 for 3 cycles. Expected: out_* stable, rn_ready_o=0; one cycle after release the next group advances.
- Commit lanes 0-1 both rd=4 with prd 60 then 61. Expected: next cycle free_valid_o=0b11, free_preg_o={4,60}, arch_rat[4]=61.
- Rename rd=9→45, commit nothing, then flush. Expected: the next group reads rs1=9 → 9; a commit in the flush cycle of rd=9→45 instead yields 45.
